rising_edge_detector: RTL and testbench
=======================================

RISING_EDGE_DETECTOR -- requirements
Module: rising_edge_detector

Interface
REQ-001 Parameter WIDTH, default 1: number of independent input channels; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per channel; legal range 0..4, where 0 means no synchronizer.
REQ-003 Parameter CNT_W, default 8: width of the edge counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-006 reset  input  1  asynchronous, active-low reset; low clears all state.
REQ-007 signal  input  WIDTH  monitored level inputs; may be asynchronous to clk.
REQ-008 count_clr  input  1  synchronous clear of edge_count.
REQ-009 outedge  output  WIDTH  registered one-cycle pulse per detected 0->1 transition, one bit per channel.
REQ-010 edge_count  output  CNT_W  saturating count of pulses on channel 0.

Function
REQ-011 Each channel SHALL pass signal through SYNC_STAGES flops to form synced, then register it into prev.
REQ-012 The registered output SHALL follow outedge <= synced & ~prev & armed.
- Timing: if N is the first clock edge that samples signal=1 after a 0, outedge SHALL go high at edge N+SYNC_STAGES.
- The pulse SHALL stay high for exactly one clock cycle.
REQ-013 A level held high for any number of cycles SHALL produce exactly one pulse.
- A new pulse requires at least one sampled 0 in between.
REQ-014 Channels SHALL be fully independent.
- Simultaneous rises on several channels SHALL produce simultaneous pulses.
REQ-015 Input pulses shorter than one clk period are not guaranteed to be detected.
- Falling transitions SHALL never assert outedge.
REQ-016 The internal armed flag SHALL be 0 after reset and SHALL set at the edge that loads prev with its first post-reset synced sample.
- Consequence: a signal high across reset release SHALL generate no pulse.
REQ-017 edge_count SHALL increment by 1 in the cycle after each outedge[0] pulse.
- It SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-018 count_clr SHALL set edge_count to 0 on the next edge.
- If count_clr coincides with an increment, the clear SHALL win and the result SHALL be 0.

Reset
REQ-019 While reset is low, the following SHALL be 0 immediately, independent of clk:
- synchronizer flops, prev and armed;
- outedge and edge_count.
REQ-020 An assertion of reset in the middle of a pulse SHALL drop outedge immediately.
- After release, no pulse SHALL be generated until REQ-016 is satisfied and a fresh 0->1 transition is seen.

Configuration
REQ-021 Macro RISING_EDGE_DETECTOR_FALL_EN SHALL control an additional output, falledge (output, WIDTH bits).
- Defined: falledge SHALL be added, with falledge <= ~synced & prev & armed, using the same latency and one-cycle width as outedge.
- Undefined: the falledge port and its logic SHALL be absent.
- In both cases outedge and edge_count SHALL behave identically.

Structure
REQ-022 A package rising_edge_detector_pkg SHALL hold:
- the default constants for WIDTH, SYNC_STAGES and CNT_W;
- the legal-range limits;
- the counter saturation constant function.
REQ-023 The synchronizer chain SHALL be one sub-module, red_sync_chain.
- It is parameterized by stage count and reset to 0, and is instantiated once per channel.
- Edge logic, arming and the counter remain in the top module.

Verification
(All scenarios use WIDTH=1, SYNC_STAGES=2, 10 ns clk.)
REQ-024 Basic pulse: reset released and signal=0 for 4 cycles, then signal=1 sampled at edge N -> outedge=1 only between edge N+2 and edge N+3; edge_count=1.
REQ-025 Held level: signal held high for 8 cycles, then low for 4 cycles -> exactly one pulse; edge_count=1.
REQ-026 Toggling: signal toggles every 4 cycles for 5 rises -> 5 pulses, each 10 ns wide and each 2 edges after capture; edge_count=5.
REQ-027 Saturation and clear:
- CNT_W=2 with 6 rises -> edge_count=3.
- count_clr on the same edge as a pulse increment -> edge_count=0.
REQ-028 Reset cases:
- Asynchronous reset asserted during a pulse -> outedge=0 within the same cycle.
- signal=1 held through reset release -> no pulse.
REQ-029 With RISING_EDGE_DETECTOR_FALL_EN defined, signal 1->0 -> falledge pulses 2 edges after capture, and outedge stays 0.

Source files
------------

// File: rtl/rising_edge_detector_pkg.sv
// Shared constants for rising_edge_detector: parameter defaults, legal ranges,
// and the saturation value of the edge counter.
package rising_edge_detector_pkg;

    localparam int WIDTH_DEF       = 1;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 8;

    localparam int WIDTH_MIN       = 1;
    localparam int WIDTH_MAX       = 32;
    localparam int SYNC_MIN        = 0;
    localparam int SYNC_MAX        = 4;
    localparam int CNT_W_MIN       = 1;
    localparam int CNT_W_MAX       = 32;

    // 2^w - 1, computed in 64 bits so w = 32 does not overflow
    function automatic logic [63:0] cnt_sat(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/rising_edge_detector_sync_chain.sv
// red_sync_chain: single-bit synchronizer of STAGES flops, async active-low
// reset to 0; STAGES = 0 degenerates to a wire.
module red_sync_chain #(
    parameter int STAGES = 2
)(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_pass
            assign q = d;
        end else begin : g_ff
            logic [STAGES-1:0] ff;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ff <= '0;
                end else begin
                    ff[0] <= d;
                    for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
                end
            end

            assign q = ff[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/rising_edge_detector.sv
// Per-channel synchronized rising-edge detector with a saturating pulse counter
// on channel 0. Define RISING_EDGE_DETECTOR_FALL_EN to add the falledge output.
module rising_edge_detector
    import rising_edge_detector_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] signal,
    input  logic             count_clr,
    output logic [WIDTH-1:0] outedge,
`ifdef RISING_EDGE_DETECTOR_FALL_EN
    output logic [WIDTH-1:0] falledge,
`endif
    output logic [CNT_W-1:0] edge_count
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_sat(CNT_W));
    localparam logic [2:0]       ARM_LAST = 3'(SYNC_STAGES);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
            SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX ||
            CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cfg
            $error("rising_edge_detector: parameter out of legal range");
        end
    endgenerate

    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] prev;
    logic             armed;
    logic [2:0]       arm_cnt;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            red_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .reset (reset),
                .d     (signal[i]),
                .q     (synced[i])
            );
        end
    endgenerate

    // The sync chain holds reset zeros for SYNC_STAGES edges; arm only once prev
    // is loaded with a real sample, so a level high across reset is not a rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev    <= '0;
            armed   <= 1'b0;
            arm_cnt <= '0;
            outedge <= '0;
        end else begin
            prev    <= synced;
            outedge <= synced & ~prev & {WIDTH{armed}};
            if (!armed) begin
                if (arm_cnt == ARM_LAST) armed   <= 1'b1;
                else                     arm_cnt <= arm_cnt + 3'd1;
            end
        end
    end

`ifdef RISING_EDGE_DETECTOR_FALL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) falledge <= '0;
        else        falledge <= ~synced & prev & {WIDTH{armed}};
    end
`endif

    // Clear has priority over a coincident increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                edge_count <= '0;
        else if (count_clr)                        edge_count <= '0;
        else if (outedge[0] && edge_count != CNT_MAX) edge_count <= edge_count + 1'b1;
    end

endmodule

// File: tb/tb_rising_edge_detector.sv
// Directed bench for rising_edge_detector: vector table for the basic/held-level
// run, loops for toggling and saturation, hand sequences for clear and reset.
module tb_rising_edge_detector;

    logic       clk;
    logic       reset;
    logic [0:0] sig_a;
    logic       clr_a;
    logic [0:0] out_a;
    logic [7:0] cnt_a;
    logic [2:0] sig_b;
    logic       clr_b;
    logic [2:0] out_b;
    logic [1:0] cnt_b;
`ifdef RISING_EDGE_DETECTOR_FALL_EN
    logic [0:0] fall_a;
    logic [2:0] fall_b;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic       sig;
        logic       clr;
        logic       exp_out;
        logic       exp_fall;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl[16];

    rising_edge_detector #(.WIDTH(1), .SYNC_STAGES(2), .CNT_W(8)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .signal     (sig_a),
        .count_clr  (clr_a),
        .outedge    (out_a),
`ifdef RISING_EDGE_DETECTOR_FALL_EN
        .falledge   (fall_a),
`endif
        .edge_count (cnt_a)
    );

    rising_edge_detector #(.WIDTH(3), .SYNC_STAGES(2), .CNT_W(2)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .signal     (sig_b),
        .count_clr  (clr_b),
        .outedge    (out_b),
`ifdef RISING_EDGE_DETECTOR_FALL_EN
        .falledge   (fall_b),
`endif
        .edge_count (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else             pass_cnt++;
    endtask

    // drive away from the active edge, then sample just after it
    task automatic step_a(input logic s, input logic c);
        @(negedge clk);
        sig_a = s;
        clr_a = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [2:0] s);
        @(negedge clk);
        sig_b = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        sig_a = '0;
        clr_a = 1'b0;
        sig_b = '0;
        clr_b = 1'b0;

        //              sig   clr   out   fall  cnt
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};  // edge N
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0};  // N+2: pulse
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1};  // falling edge: no outedge
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0};  // clear before toggling

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_a", out_a, 1'b0);
        chk("reset_cnt_a", cnt_a, 8'd0);
        chk("reset_out_b", out_b, 3'd0);
        chk("reset_cnt_b", cnt_b, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step_a(tbl[i].sig, tbl[i].clr);
            chk($sformatf("tbl_out[%0d]", i), out_a, tbl[i].exp_out);
            chk($sformatf("tbl_cnt[%0d]", i), cnt_a, tbl[i].exp_cnt);
`ifdef RISING_EDGE_DETECTOR_FALL_EN
            chk($sformatf("tbl_fall[%0d]", i), fall_a, tbl[i].exp_fall);
`endif
        end

        // five rises, 4 cycles high / 4 low; pulse 2 edges after capture
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 8; c++) begin
                step_a(c < 4, 1'b0);
                chk($sformatf("tog_out[%0d.%0d]", r, c), out_a, c == 2);
                chk($sformatf("tog_cnt[%0d.%0d]", r, c), cnt_a, r + ((c >= 3) ? 1 : 0));
`ifdef RISING_EDGE_DETECTOR_FALL_EN
                chk($sformatf("tog_fall[%0d.%0d]", r, c), fall_a, c == 6);
`endif
            end
        end

        // six rises on ch0 of a 2-bit counter: saturate at 3; ch1/ch2 independent
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) begin
                logic [2:0] s;
                logic [2:0] e;
                int         ec;
                s[0] = (c < 2);
                s[1] = (r == 0 || r == 3) && (c < 2);
                s[2] = (r == 1) && (c < 2);
                e[0] = (c == 2);
                e[1] = (r == 0 || r == 3) && (c == 2);
                e[2] = (r == 1) && (c == 2);
                ec   = r + ((c == 3) ? 1 : 0);
                if (ec > 3) ec = 3;
                step_b(s);
                chk($sformatf("sat_out[%0d.%0d]", r, c), out_b, e);
                chk($sformatf("sat_cnt[%0d.%0d]", r, c), cnt_b, ec);
            end
        end

        // count_clr on the same edge as the increment: clear wins
        repeat (3) step_a(1'b0, 1'b0);
        step_a(1'b1, 1'b0);
        step_a(1'b1, 1'b0);
        step_a(1'b1, 1'b0);
        chk("clr_pulse_out", out_a, 1'b1);
        chk("clr_pulse_cnt", cnt_a, 8'd5);
        step_a(1'b1, 1'b1);
        chk("clr_coincide_cnt", cnt_a, 8'd0);
        chk("clr_coincide_out", out_a, 1'b0);
        step_a(1'b1, 1'b0);
        chk("clr_after_cnt", cnt_a, 8'd0);

        // async reset in the middle of a pulse
        repeat (3) step_a(1'b0, 1'b0);
        step_a(1'b1, 1'b0);
        step_a(1'b1, 1'b0);
        step_a(1'b1, 1'b0);
        chk("pre_rst_out", out_a, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out", out_a, 1'b0);
        chk("mid_rst_cnt", cnt_a, 8'd0);

        // signal held high through reset release: no pulse
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_a(1'b1, 1'b0);
            chk($sformatf("held_rst_out[%0d]", i), out_a, 1'b0);
        end
        chk("held_rst_cnt", cnt_a, 8'd0);

        // a fresh 0->1 afterwards is detected
        repeat (3) step_a(1'b0, 1'b0);
        step_a(1'b1, 1'b0);
        step_a(1'b1, 1'b0);
        chk("fresh_early", out_a, 1'b0);
        step_a(1'b1, 1'b0);
        chk("fresh_out", out_a, 1'b1);
        step_a(1'b1, 1'b0);
        chk("fresh_end", out_a, 1'b0);
        chk("fresh_cnt", cnt_a, 8'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
